// File: rtl/rv32i_types.sv
// Shared RV32I type definitions used by the memory stage: funct3 encodings and FSM states.
package rv32i_types;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_funct3_t;

    typedef enum logic {
        IDLE,
        ACCESS
    } mem_stage_state_t;

    // Half accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic result;
        result = 1'b0;
        case (funct3)
            3'b001, 3'b101: result = off[0];
            3'b010:         result = (off != 2'b00);
            default:        result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane steering: store mask/data placement and load lane extraction/extension.
module mem_align
    import rv32i_types::*;
(
    input  logic [2:0]  store_funct3,
    input  logic [1:0]  store_off,
    input  logic [31:0] store_data,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    input  logic [2:0]  load_funct3,
    input  logic [1:0]  load_off,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    always_comb begin
        wmask = 4'b0000;
        wdata = 32'd0;
        case (store_funct3_t'(store_funct3))
            F3_SB: begin
                wmask = 4'b0001 << store_off;
                wdata = store_data << {store_off, 3'b000};
            end
            F3_SH: begin
                wmask = 4'b0011 << {store_off[1], 1'b0};
                wdata = store_data << {store_off[1], 4'b0000};
            end
            F3_SW: begin
                wmask = 4'b1111;
                wdata = store_data;
            end
            default: begin
                wmask = 4'b0000;
                wdata = 32'd0;
            end
        endcase
    end

    always_comb begin
        lane_b    = rdata[{load_off, 3'b000} +: 8];
        lane_h    = rdata[{load_off[1], 4'b0000} +: 16];
        load_data = 32'd0;
        case (load_funct3_t'(load_funct3))
            F3_LB:   load_data = 32'(lane_b);
            F3_LBU:  load_data = {24'd0, lane_b};
            F3_LH:   load_data = 32'(lane_h);
            F3_LHU:  load_data = {16'd0, lane_h};
            F3_LW:   load_data = rdata;
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: dmem request/response handshake, lane alignment, registered writeback.
// Optional macro MEM_STAGE_MISALIGN_TRAP_EN traps misaligned half/word accesses at accept.
module mem_stage
    import rv32i_types::*;
#(
    parameter int unsigned RESP_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        in_load_regfile,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_alu_out,
    input  logic [31:0] in_rs2,
    input  logic        flush,
    output logic [31:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_load_regfile,
    output logic        wb_err,
    output logic        wb_misaligned
);

    localparam logic [31:0] TO_LAST = 32'(RESP_TIMEOUT) - 32'd1;

    mem_stage_state_t state, state_next;
    logic [31:0] cnt;
    logic        accept, start_access, finish, abort, trap;
    logic        is_mem, misaligned, timeout_hit;
    logic [3:0]  align_wmask;
    logic [31:0] align_wdata, load_data;

    logic [4:0]  rd_p1;
    logic [2:0]  funct3_p1;
    logic [1:0]  off_p1;
    logic        store_p1, load_regfile_p1, flushed_p1;

    assign in_ready    = (state == IDLE);
    assign is_mem      = in_mem_read | in_mem_write;
    assign timeout_hit = (RESP_TIMEOUT != 0) && (cnt == TO_LAST);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(in_funct3, in_alu_out[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    mem_align u_align (
        .store_funct3 (in_funct3),
        .store_off    (in_alu_out[1:0]),
        .store_data   (in_rs2),
        .wmask        (align_wmask),
        .wdata        (align_wdata),
        .load_funct3  (funct3_p1),
        .load_off     (off_p1),
        .rdata        (dmem_rdata),
        .load_data    (load_data)
    );

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        start_access = 1'b0;
        finish       = 1'b0;
        abort        = 1'b0;
        trap         = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && !flush) begin
                    accept = 1'b1;
                    if (is_mem && misaligned) begin
                        trap = 1'b1;
                    end else if (is_mem) begin
                        start_access = 1'b1;
                        state_next   = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (dmem_resp) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Accept -> request stage: capture the op fields the response side needs.
    always_ff @(posedge clk) begin
        if (start_access) begin
            rd_p1           <= in_rd;
            funct3_p1       <= in_funct3;
            off_p1          <= in_alu_out[1:0];
            store_p1        <= in_mem_write;
            load_regfile_p1 <= in_load_regfile;
        end
    end

    // Request/response -> writeback stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= 32'd0;
            flushed_p1      <= 1'b0;
            dmem_address    <= 32'd0;
            dmem_read       <= 1'b0;
            dmem_write      <= 1'b0;
            dmem_wmask      <= 4'b0000;
            dmem_wdata      <= 32'd0;
            wb_valid        <= 1'b0;
            wb_rd           <= 5'd0;
            wb_data         <= 32'd0;
            wb_load_regfile <= 1'b0;
            wb_err          <= 1'b0;
            wb_misaligned   <= 1'b0;
        end else begin
            state    <= state_next;
            wb_valid <= 1'b0;
            if (accept && !start_access) begin
                wb_valid        <= 1'b1;
                wb_rd           <= in_rd;
                wb_data         <= in_alu_out;
                wb_load_regfile <= in_load_regfile && !trap;
                wb_err          <= 1'b0;
                wb_misaligned   <= trap;
            end
            if (start_access) begin
                cnt          <= 32'd0;
                flushed_p1   <= 1'b0;
                dmem_read    <= !in_mem_write;
                dmem_write   <= in_mem_write;
                dmem_address <= {in_alu_out[31:2], 2'b00};
                dmem_wmask   <= in_mem_write ? align_wmask : 4'b0000;
                dmem_wdata   <= in_mem_write ? align_wdata : 32'd0;
            end
            if (state == ACCESS) begin
                cnt <= cnt + 32'd1;
                if (flush) flushed_p1 <= 1'b1;
                // A flushed op still finishes its bus transaction; only the writeback is hidden.
                if (finish || abort) begin
                    dmem_read       <= 1'b0;
                    dmem_write      <= 1'b0;
                    wb_valid        <= !(flushed_p1 || flush);
                    wb_rd           <= rd_p1;
                    wb_data         <= (finish && !store_p1) ? load_data : 32'd0;
                    wb_load_regfile <= finish && !store_p1 && load_regfile_p1;
                    wb_err          <= abort;
                    wb_misaligned   <= 1'b0;
                end
            end
        end
    end

endmodule
